// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer -- fetch PC register with branch/jump/call/return steering and
//                 a circular return-address stack. Option: PC_ALIGN_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VEC = '0,
    parameter logic [WIDTH-1:0]  TRAP_VEC  = 'h80,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_offset,
    input  logic             jmp_valid,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] ret_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             pc_valid,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             align_err
);

    localparam int unsigned         c_PTR_W    = $clog2(RAS_DEPTH);
    localparam logic [c_PTR_W:0]    c_DEPTH    = (c_PTR_W + 1)'(RAS_DEPTH);
    localparam logic [WIDTH-1:0]    c_FOUR     = WIDTH'(4);
    localparam logic [WIDTH-1:0]    c_LOW_MASK = WIDTH'(3);

    localparam logic [0:0] c_ST_INIT = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   w_pc_next;
    logic [WIDTH-1:0]   r_ras [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_top;
    logic [c_PTR_W:0]   r_count;
    logic               r_ovf;
    logic               r_align_err;

    logic               w_run;
    logic               w_ras_has;
    logic [WIDTH-1:0]   w_ret_tgt;
    logic [WIDTH-1:0]   w_sel_tgt;
    logic [WIDTH-1:0]   w_redirect;
    logic               w_do_ret;
    logic               w_do_jmp;
    logic               w_do_br;
    logic               w_hold;
    logic               w_fault;
    logic               w_push;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_top_inc;
    logic               w_unused;

    // ---------------- state machine: reset -> first-edge -> running ---------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_INIT: w_state_next = c_ST_RUN;
            c_ST_RUN:  w_state_next = c_ST_RUN;
            default:   w_state_next = c_ST_INIT;
        endcase
    end

    always_comb begin
        pc_valid = 1'b0;
        case (r_state)
            c_ST_RUN: pc_valid = 1'b1;
            default:  pc_valid = 1'b0;
        endcase
    end

    // ---------------- next-PC selection -------------------------------------
    assign w_run     = (r_state == c_ST_RUN);
    assign w_ras_has = (r_count != '0);
    assign w_ret_tgt = w_ras_has ? r_ras[r_top] : ret_addr;
    assign w_sel_tgt = ret ? w_ret_tgt : jmp_target;

    assign w_do_ret  = w_run & ret;
    assign w_do_jmp  = w_run & ~ret & jmp_valid;
    assign w_do_br   = w_run & ~ret & ~jmp_valid & br_taken;
    assign w_hold    = ~w_run | (stall & ~ret & ~jmp_valid & ~br_taken);

`ifdef PC_ALIGN_CHECK_EN
    assign w_fault    = (w_do_ret | w_do_jmp) & (w_sel_tgt[1:0] != 2'b00);
    assign w_redirect = w_fault ? TRAP_VEC : w_sel_tgt;
`else
    assign w_fault    = 1'b0;
    assign w_redirect = w_sel_tgt & ~c_LOW_MASK;
`endif

    assign w_unused = ^TRAP_VEC;

    always_comb begin
        w_pc_next = r_pc + c_FOUR;
        if (w_hold) begin
            w_pc_next = r_pc;
        end else if (w_do_ret | w_do_jmp) begin
            w_pc_next = w_redirect;
        end else if (w_do_br) begin
            w_pc_next = r_pc + c_FOUR + (br_offset << 2);
        end
    end

    // A call paired with a ret still pushes; pop-then-push replaces the top.
    assign w_pop     = w_do_ret & w_ras_has;
    assign w_push    = w_run & jmp_valid & call & ~w_fault;
    assign w_top_inc = r_top + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc        <= RESET_VEC;
            r_top       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_align_err <= w_fault;
            if (w_push && !w_pop) begin
                r_top <= w_top_inc;
                if (r_count == c_DEPTH) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_pop && !w_push) begin
                r_top   <= r_top - 1'b1;
                r_count <= r_count - 1'b1;
            end
        end
    end

    // RAS storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            if (w_pop) begin
                r_ras[r_top] <= r_pc + c_FOUR;
            end else begin
                r_ras[w_top_inc] <= r_pc + c_FOUR;
            end
        end
    end

    assign pc        = r_pc;
    assign pc_plus4  = r_pc + c_FOUR;
    assign ras_empty = (r_count == '0);
    assign ras_full  = (r_count == c_DEPTH);
    assign ras_ovf   = r_ovf;
    assign align_err = r_align_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer -- directed table-driven bench for pc_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_offset;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        call;
    logic        ret;
    logic [31:0] ret_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_ovf;
    logic        align_err;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .WIDTH     (32),
        .RESET_VEC (32'h0),
        .TRAP_VEC  (32'h80),
        .RAS_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_offset  (br_offset),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .call       (call),
        .ret        (ret),
        .ret_addr   (ret_addr),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .pc_valid   (pc_valid),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full),
        .ras_ovf    (ras_ovf),
        .align_err  (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        br;
        logic [31:0] off;
        logic        jv;
        logic [31:0] jt;
        logic        call;
        logic        ret;
        logic [31:0] ra;
        logic [31:0] epc;
        logic        evalid;
        logic        eempty;
        logic        efull;
        logic        eovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic s, logic b, logic [31:0] o, logic j,
                                logic [31:0] t, logic c, logic rt, logic [31:0] a,
                                logic [31:0] ep, logic ev, logic ee, logic ef, logic eo);
        vec_t v;
        v.rst_n = r;  v.stall = s; v.br = b;  v.off = o;  v.jv = j;
        v.jt = t;     v.call = c;  v.ret = rt; v.ra = a;
        v.epc = ep;   v.evalid = ev; v.eempty = ee; v.efull = ef; v.eovf = eo;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst_n = v.rst_n; stall = v.stall; br_taken = v.br; br_offset = v.off;
        jmp_valid = v.jv; jmp_target = v.jt; call = v.call; ret = v.ret; ret_addr = v.ra;
    endtask

    task automatic idle_in();
        rst_n = 1'b1; stall = 1'b0; br_taken = 1'b0; br_offset = '0;
        jmp_valid = 1'b0; jmp_target = '0; call = 1'b0; ret = 1'b0; ret_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] epc, input logic ev,
                             input logic ee, input logic ef, input logic eo, input logic ea);
        check({tag, " pc"},        pc,               epc);
        check({tag, " pc_plus4"},  pc_plus4,         epc + 32'd4);
        check({tag, " pc_valid"},  {31'd0, pc_valid},  {31'd0, ev});
        check({tag, " ras_empty"}, {31'd0, ras_empty}, {31'd0, ee});
        check({tag, " ras_full"},  {31'd0, ras_full},  {31'd0, ef});
        check({tag, " ras_ovf"},   {31'd0, ras_ovf},   {31'd0, eo});
        check({tag, " align_err"}, {31'd0, align_err}, {31'd0, ea});
    endtask

    logic [31:0] ret_exp [5];
    logic [31:0] tgt;

    initial begin
        //                rst s  br off           jv jt            c  r  ra            epc           v  e  f  o
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h500,      1, 0, 32'h0,        32'h0,        1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h4,        1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h8,        1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'hC,        1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h10,       1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 32'hFFFFFFFE, 0, 32'h0,        0, 0, 32'h0,        32'hC,        1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'hC,        1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'hC,        1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'hC,        1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'h100,      0, 0, 32'h0,        32'h100,      1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 32'h1,        0, 32'h0,        0, 0, 32'h0,        32'h108,      1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h20,       0, 0, 32'h0,        32'h20,       1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h400,      1, 0, 32'h0,        32'h400,      1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h404,      1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h408,      1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hDEAD0,    32'h24,       1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hDEAD0,    32'hDEAD0,    1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 32'h5,        1, 32'h700,      0, 1, 32'h600,      32'h600,      1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 32'h5,        1, 32'h700,      0, 0, 32'h0,        32'h700,      1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 32'h5,        0, 32'h0,        0, 0, 32'h0,        32'h718,      1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 0, 32'h0,        32'hFFFFFFFC, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h4C,       0, 0, 32'h0,        32'h4C,       1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h60,       1, 0, 32'h0,        32'h60,       1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h900,      1, 1, 32'h0,        32'h50,       1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h3330,     32'h64,       1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h3330,     32'h3330,     1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 32'h900,      1, 1, 32'h2220,     32'h2220,     1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h10,       32'h3334,     1, 1, 0, 0));

        ret_exp[0] = 32'h404; ret_exp[1] = 32'h304; ret_exp[2] = 32'h204;
        ret_exp[3] = 32'h104; ret_exp[4] = 32'h999C;

        idle_in();
        rst_n = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].epc, vecs[i].evalid,
                      vecs[i].eempty, vecs[i].efull, vecs[i].eovf, 1'b0);
        end

        // Five calls into a four-deep RAS, then unwind past the overwritten entry.
        idle_in(); jmp_valid = 1'b1; jmp_target = 32'h0;
        step();
        check_all("ovf_setup", 32'h0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tgt = (i == 4) ? 32'h800 : 32'((i + 1) * 32'h100);
            idle_in(); jmp_valid = 1'b1; call = 1'b1; jmp_target = tgt;
            step();
            check_all($sformatf("call%0d", i), tgt, 1, 0, (i >= 3), (i == 4), 0);
        end
        for (int i = 0; i < 5; i++) begin
            idle_in(); ret = 1'b1; ret_addr = 32'h999C;
            step();
            check_all($sformatf("ret%0d", i), ret_exp[i], 1, (i >= 3), 0, 1, 0);
        end

        // Reset in the middle of a call clears the RAS and the sticky overflow.
        idle_in(); rst_n = 1'b0; jmp_valid = 1'b1; call = 1'b1; jmp_target = 32'h500;
        step();
        check_all("midrst", 32'h0, 0, 1, 0, 0, 0);
        idle_in(); ret = 1'b1; ret_addr = 32'h700;
        step();
        check_all("midrst_first", 32'h0, 1, 1, 0, 0, 0);
        idle_in(); ret = 1'b1; ret_addr = 32'h700;
        step();
        check_all("midrst_ret", 32'h700, 1, 1, 0, 0, 0);

        // Misaligned call target, then a misaligned return target.
        idle_in(); jmp_valid = 1'b1; call = 1'b1; jmp_target = 32'h102;
        step();
`ifdef PC_ALIGN_CHECK_EN
        check_all("align_call", 32'h80, 1, 1, 0, 0, 1);
`else
        check_all("align_call", 32'h100, 1, 0, 0, 0, 0);
`endif
        idle_in();
        step();
`ifdef PC_ALIGN_CHECK_EN
        check_all("align_after", 32'h84, 1, 1, 0, 0, 0);
`else
        check_all("align_after", 32'h104, 1, 0, 0, 0, 0);
`endif
        idle_in(); ret = 1'b1; ret_addr = 32'h3333;
        step();
`ifdef PC_ALIGN_CHECK_EN
        check_all("align_ret", 32'h80, 1, 1, 0, 0, 1);
`else
        check_all("align_ret", 32'h704, 1, 1, 0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised, clocked successor to the combinational program counter: it holds the fetch PC and computes the next PC from sequential increment, relative branch, absolute jump, and call/return. A small return-address stack (RAS) predicts return targets. Sits at the head of the fetch stage, feeding instruction memory and the pipeline's PC+4 path.

Parameters:
WIDTH, 32, PC/address width in bits.
RESET_VEC, 0, PC value loaded on reset.
TRAP_VEC, 32'h80, PC loaded on a misaligned target (optional feature only).
RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
stall  input  1  hold PC (pipeline hazard)
br_taken  input  1  take relative branch this cycle
br_offset  input  WIDTH  signed word offset for branch
jmp_valid  input  1  absolute jump this cycle
jmp_target  input  WIDTH  absolute jump target
call  input  1  qualifies jmp_valid as a call (jal): push return address
ret  input  1  return this cycle (jr $ra)
ret_addr  input  WIDTH  architectural $ra, used when RAS empty
pc  output  WIDTH  current fetch PC (registered)
pc_plus4  output  WIDTH  pc + 4 (combinational from pc)
pc_valid  output  1  PC is fetchable
ras_empty  output  1  RAS holds no entries
ras_full  output  1  RAS holds RAS_DEPTH entries
ras_ovf  output  1  sticky: a push overwrote the oldest entry
align_err  output  1  one-cycle misaligned-target flag (optional feature)

Behaviour:
- One clock; reset is synchronous and active-low: clk, rst_n. All state updates on clk rising edge.
- Reset (rst_n=0 at edge): pc=RESET_VEC, pc_valid=0, RAS count=0, ras_empty=1, ras_full=0, ras_ovf=0, align_err=0. Reset overrides every other input.
- First edge with rst_n=1: pc_valid→1, pc stays RESET_VEC, all control inputs ignored. After that, pc_valid stays 1 until the next reset.
- Next-PC priority (highest first): ret > jmp_valid > br_taken > stall > increment.
  - ret: target = RAS top if not empty, else ret_addr; pop if not empty.
  - jmp_valid: target = jmp_target; if call, push pc+4.
  - br_taken: target = pc + 4 + (br_offset << 2).
  - stall: pc holds; RAS untouched.
  - otherwise: pc = pc + 4.
- Redirects override stall (a flush beats a hazard hold).
- All arithmetic is modulo 2^WIDTH; wrap at the top of the address space is silent.
- Latency: a control input sampled at edge N produces the new pc after edge N. pc_plus4 follows pc in the same cycle.
- RAS behaviour:
  - Circular buffer with a count.
  - Push when full overwrites the oldest entry, keeps count=RAS_DEPTH, and sets ras_ovf (cleared only by reset).
  - Pop when empty: no change.
  - ret together with jmp_valid&call: ret wins the PC; the RAS does pop-then-push, so the top is replaced by pc+4 and count is unchanged (count+1 if it was empty).
- Without the optional feature: bits [1:0] of every jump/return target are forced to 0, and align_err is tied 0.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined: if the selected jmp_target or return target has bits [1:0] ≠ 0, pc loads TRAP_VEC, align_err=1 for exactly that cycle, and no RAS push occurs for that call. A pop for a ret still occurs.
- Undefined: target low bits are masked to 0 and the align_err output is constant 0.

Test Plan:
- Reset then free-run: rst_n low 2 cycles then high → pc=0, pc_valid=0; next edge pc_valid=1, pc=0; following edges pc=4, 8, 12.
- Branch/stall: at pc=0x10, br_taken=1, br_offset=-2 → pc=0x0C. Then stall=1 for 3 cycles → pc holds 0x0C. Then stall=1 with jmp_valid=1, jmp_target=0x100 → pc=0x100.
- Call/return: at pc=0x20, call+jmp_valid to 0x400 → pc=0x400, ras_empty=0. Advance 2 cycles, then ret with ret_addr=0xDEAD0 → pc=0x24, ras_empty=1.
- RAS overflow (RAS_DEPTH=4): 5 calls from pcs 0x0, 0x100, 0x200, 0x300, 0x400 → ras_full=1, ras_ovf=1. Then 5 rets with ret_addr=0x999C → targets 0x404, 0x304, 0x204, 0x104, then 0x999C.
- Wrap and simultaneous events: pc=0xFFFFFFFC with increment → 0x0. Simultaneous ret+call with RAS top 0x50 at pc=0x60 → pc=0x50, new top=0x64, count unchanged.
- Optional feature / reset mid-run: with PC_ALIGN_CHECK_EN, jmp_target=0x102 → pc=0x80 and align_err one-cycle pulse. Without the macro → pc=0x100. Asserting rst_n=0 mid-call clears the RAS and ras_ovf.
